// File: rtl/regfile_pkg.sv
// Shared definitions for the RegisterFile writeback arbiter: widths, the
// hard-wired zero register index and the writeback requester encoding.
package regfile_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef enum logic {
        WB_ALU = 1'b0,
        WB_MEM = 1'b1
    } wb_src_e;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: holds the last-granted pointer and produces
// combinational grants from the request pair, gated by Stall and reset.
module rr_arb2
    import regfile_pkg::*;
(
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic [1:0] Req,
    input  logic       Stall,
    output logic [1:0] Gnt
);

    wb_src_e    last_r;
    logic [1:0] gnt_s;

    // Grant selection; on a tie the port that did not win last time goes first
    always_comb begin
        gnt_s = 2'b00;
        if (!Rst_n || Stall) begin
            gnt_s = 2'b00;
        end else begin
            case (Req)
                2'b01:   gnt_s = 2'b01;
                2'b10:   gnt_s = 2'b10;
                2'b11:   gnt_s = (last_r == WB_ALU) ? 2'b10 : 2'b01;
                default: gnt_s = 2'b00;
            endcase
        end
    end

    assign Gnt = gnt_s;

    // Round-robin pointer; reset to WB_MEM so the ALU wins the first tie
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            last_r <= WB_MEM;
        end else if (gnt_s[0]) begin
            last_r <= WB_ALU;
        end else if (gnt_s[1]) begin
            last_r <= WB_MEM;
        end else begin
            last_r <= last_r;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the RegisterFile write port between the ALU and load-unit writeback
// sources. Optional write-before-commit forwarding is enabled by WB_FWD_EN.
module regfile_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Stall,
    input  logic              Req0,
    input  logic              Req1,
    input  logic [ADDR_W-1:0] Reg0,
    input  logic [ADDR_W-1:0] Reg1,
    input  logic [DATA_W-1:0] Data0,
    input  logic [DATA_W-1:0] Data1,
    output logic              Gnt0,
    output logic              Gnt1,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] WriteRegister,
    output logic [DATA_W-1:0] WriteData,
    output logic [CNT_W-1:0]  ConflictCnt
`ifdef WB_FWD_EN
    ,
    input  logic [ADDR_W-1:0] RdReg1,
    input  logic [ADDR_W-1:0] RdReg2,
    output logic              FwdHit1,
    output logic              FwdHit2,
    output logic [DATA_W-1:0] FwdData1,
    output logic [DATA_W-1:0] FwdData2
`endif
);
    import regfile_pkg::*;

    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    logic [1:0]        gnt_s;
    logic              xfer_s;
    logic              conflict_s;
    logic [ADDR_W-1:0] sel_reg_s;
    logic [DATA_W-1:0] sel_data_s;

    logic              reg_write_r;
    logic [ADDR_W-1:0] write_register_r;
    logic [DATA_W-1:0] write_data_r;
    logic [CNT_W-1:0]  conflict_cnt_r;

    rr_arb2 u_arb (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .Req   ({Req1, Req0}),
        .Stall (Stall),
        .Gnt   (gnt_s)
    );

    assign Gnt0       = gnt_s[0];
    assign Gnt1       = gnt_s[1];
    assign xfer_s     = gnt_s[0] | gnt_s[1];
    assign conflict_s = Req0 & Req1 & ~Stall;

    // Mux the granted source onto the write-port path
    always_comb begin
        sel_reg_s  = Reg0;
        sel_data_s = Data0;
        if (gnt_s[1]) begin
            sel_reg_s  = Reg1;
            sel_data_s = Data1;
        end else begin
            sel_reg_s  = Reg0;
            sel_data_s = Data0;
        end
    end

    // Write-port registers; $zero writes are consumed but never strobed
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            reg_write_r      <= 1'b0;
            write_register_r <= '0;
            write_data_r     <= '0;
        end else if (xfer_s) begin
            reg_write_r      <= (sel_reg_s != ZERO_IDX);
            write_register_r <= sel_reg_s;
            write_data_r     <= sel_data_s;
        end else begin
            reg_write_r      <= 1'b0;
        end
    end

    // Saturating count of cycles where both sources contend
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            conflict_cnt_r <= '0;
        end else if (conflict_s && (conflict_cnt_r != CNT_MAX)) begin
            conflict_cnt_r <= conflict_cnt_r + CNT_W'(1);
        end else begin
            conflict_cnt_r <= conflict_cnt_r;
        end
    end

    assign RegWrite      = reg_write_r;
    assign WriteRegister = write_register_r;
    assign WriteData     = write_data_r;
    assign ConflictCnt   = conflict_cnt_r;

`ifdef WB_FWD_EN
    // Bypass the pending write to readers before RegisterFile commits it
    always_comb begin
        FwdHit1  = 1'b0;
        FwdHit2  = 1'b0;
        FwdData1 = '0;
        FwdData2 = '0;
        if (reg_write_r && (write_register_r == RdReg1) && (RdReg1 != ZERO_IDX)) begin
            FwdHit1  = 1'b1;
            FwdData1 = write_data_r;
        end else begin
            FwdHit1  = 1'b0;
            FwdData1 = '0;
        end
        if (reg_write_r && (write_register_r == RdReg2) && (RdReg2 != ZERO_IDX)) begin
            FwdHit2  = 1'b1;
            FwdData2 = write_data_r;
        end else begin
            FwdHit2  = 1'b0;
            FwdData2 = '0;
        end
    end
`endif

endmodule
